// File: rtl/iwm_ctrl.sv
// iwm_ctrl: IWM floppy controller register model ($C0E0-$C0EF), no media attached
// Ports:
//   clk, reset (async, active-high), cen (timer clock enable)
//   addr[7:0] (only [3:0] decoded), din[7:0], rw (1=read), strobe (one-clk access)
//   dout[7:0] combinational read data, DISK35[7:0] ($C031: bit6 3.5" select)
// Optional: define IWM_TRACE_EN to print every strobed access in simulation.
module iwm_ctrl #(
    parameter int MOTOR_OFF_DELAY = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cen,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rw,
    input  logic       strobe,
    input  logic [7:0] DISK35
);
    localparam int TW = $clog2(MOTOR_OFF_DELAY + 1);
    // soft switches indexed by addr[3:1]: ph0..ph3, MOTOR, DRIVESEL, Q6, Q7
    logic [7:0]    r_sw;
    logic [4:0]    r_mode;
    logic          r_active;
    logic [TW-1:0] r_timer;
    logic          w_q6;
    logic          w_q7;
    logic          w_motor_sel;
    logic          w_motor_nxt;
    logic          w_mode_wr;
    logic          w_unused;

    // effective Q6/Q7: the current address's switch effect is already applied
    assign w_q6        = (addr[3:1] == 3'd6) ? addr[0] : r_sw[6];
    assign w_q7        = (addr[3:1] == 3'd7) ? addr[0] : r_sw[7];
    assign w_motor_sel = strobe && (addr[3:1] == 3'd4);
    assign w_motor_nxt = w_motor_sel ? addr[0] : r_sw[4];
    assign w_mode_wr   = strobe && !rw && addr[0] && w_q7 && w_q6 && !r_sw[4] && !r_active;
    assign w_unused    = ^{addr[7:4], din[7:5], DISK35[7], DISK35[5:0], r_sw[5], r_sw[3:0]};

    // data register reads all-ones only while a 5.25" drive spins with no disk
    assign dout = w_q7 ? (w_q6 ? 8'h00 : 8'hC0)
                : w_q6 ? {1'b1, 1'b0, r_active, r_mode}
                : (r_active && !DISK35[6]) ? 8'hFF : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw     <= '0;
            r_mode   <= '0;
            r_active <= 1'b0;
            r_timer  <= '0;
        end else begin
            if (strobe)
                r_sw[addr[3:1]] <= addr[0];
            if (w_mode_wr)
                r_mode <= din[4:0];
            if (w_motor_sel && addr[0]) begin
                r_active <= 1'b1;
                r_timer  <= '0;
            end else if (w_motor_nxt) begin
                r_timer <= '0;
            end else if (r_mode[2]) begin
                r_active <= 1'b0;
                r_timer  <= '0;
            end else if (r_active && cen) begin
                if (r_timer == TW'(MOTOR_OFF_DELAY - 1)) begin
                    r_active <= 1'b0;
                    r_timer  <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

`ifdef IWM_TRACE_EN
    always @(posedge clk)
        if (strobe)
            $display("iwm: addr=%02h rw=%b din=%02h dout=%02h q7=%b q6=%b motor=%b active=%b",
                     addr, rw, din, dout, w_q7, w_q6, r_sw[4], r_active);
`endif
endmodule

// File: tb/tb_iwm_ctrl.sv
// tb_iwm_ctrl: table-driven and sequence checks of iwm_ctrl with a dout scoreboard
module tb_iwm_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cen = 1'b0;
    logic [7:0] addr = 8'hE0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       rw = 1'b1;
    logic       strobe = 1'b0;
    logic [7:0] disk35 = 8'h00;

    int n_run = 0;
    int n_fail = 0;
    logic [7:0] sb_e[$];
    string      sb_nm[$];

    typedef struct {
        logic [7:0] a;
        logic       rw;
        logic [7:0] d;
        logic [7:0] k;
        logic [7:0] e;
    } vec_t;
    vec_t vecs[26];

    iwm_ctrl #(.MOTOR_OFF_DELAY(10)) dut (
        .clk(clk), .reset(reset), .cen(cen), .addr(addr), .din(din),
        .dout(dout), .rw(rw), .strobe(strobe), .DISK35(disk35)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_e.size() > 0) begin
            logic [7:0] e;
            string nm;
            e  = sb_e.pop_front();
            nm = sb_nm.pop_front();
            n_run++;
            if (dout !== e) begin
                n_fail++;
                $display("FAIL %s: dout=%02h expected=%02h", nm, dout, e);
            end
        end
    end

    // one clk cycle of stimulus, entered and left at posedge+1
    task automatic step(input logic [7:0] a, input logic w, input logic [7:0] d,
                        input logic [7:0] k, input logic s, input logic c,
                        input logic [7:0] e, input string nm);
        addr = a; rw = w; din = d; disk35 = k; strobe = s; cen = c;
        sb_e.push_back(e);
        sb_nm.push_back(nm);
        @(negedge clk);
        @(posedge clk);
        #1;
        strobe = 1'b0; cen = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [7:0] e, input string nm);
        for (int k = 0; k < n; k++)
            step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, e, $sformatf("%s%0d", nm, k));
    endtask

    initial begin
        vecs[0]  = '{8'hE0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{8'hEC, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{8'hED, 1'b1, 8'h00, 8'h00, 8'h80};
        vecs[3]  = '{8'hEE, 1'b1, 8'h00, 8'h00, 8'h80};
        vecs[4]  = '{8'hEF, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{8'hEF, 1'b0, 8'h1F, 8'h00, 8'h00};
        vecs[6]  = '{8'hEE, 1'b1, 8'h00, 8'h00, 8'h9F};
        vecs[7]  = '{8'hE9, 1'b1, 8'h00, 8'h00, 8'h9F};
        vecs[8]  = '{8'hEE, 1'b1, 8'h00, 8'h00, 8'hBF};
        vecs[9]  = '{8'hEC, 1'b1, 8'h00, 8'h00, 8'hFF};
        vecs[10] = '{8'hE0, 1'b1, 8'h00, 8'h40, 8'h00};
        vecs[11] = '{8'hE0, 1'b1, 8'h00, 8'h00, 8'hFF};
        vecs[12] = '{8'hE8, 1'b1, 8'h00, 8'h00, 8'hFF};
        vecs[13] = '{8'hE0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[14] = '{8'hED, 1'b1, 8'h00, 8'h00, 8'h9F};
        vecs[15] = '{8'hED, 1'b0, 8'h04, 8'h00, 8'h9F};
        vecs[16] = '{8'hEE, 1'b1, 8'h00, 8'h00, 8'h9F};
        vecs[17] = '{8'hEF, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[18] = '{8'hE0, 1'b0, 8'h04, 8'h00, 8'h00};
        vecs[19] = '{8'hEE, 1'b1, 8'h00, 8'h00, 8'h9F};
        vecs[20] = '{8'hEF, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[21] = '{8'hEF, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[22] = '{8'hEE, 1'b1, 8'h00, 8'h00, 8'h80};
        vecs[23] = '{8'hEF, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[24] = '{8'hEC, 1'b1, 8'h00, 8'h00, 8'hC0};
        vecs[25] = '{8'hE0, 1'b1, 8'h00, 8'h00, 8'hC0};

        @(posedge clk); #1;
        step(8'hE0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, "reset_data");
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, "reset_status");
        reset = 1'b0;

        for (int i = 0; i < 26; i++)
            step(vecs[i].a, vecs[i].rw, vecs[i].d, vecs[i].k, 1'b1, 1'b0, vecs[i].e,
                 $sformatf("vec%0d", i));

        // reset with Q7 set: switches clear at once
        reset = 1'b1;
        step(8'hE0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, "rst_mid_data");
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, "rst_mid_status");
        reset = 1'b0;

        // plain countdown, mode[2]=0: exactly 10 cen ticks, idle cycles do not count
        step(8'hE9, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, "a_on");
        step(8'hE8, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, "a_off");
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA0, "a_idle");
        ticks(10, 8'hA0, "a_tick");
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, "a_expired");

        // cancel at tick 5 (strobe and cen together), then off-strobe counts a tick
        step(8'hE9, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, "b_on");
        step(8'hE8, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, "b_off");
        ticks(3, 8'hA0, "b_tick");
        step(8'hE9, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, "b_reon");
        ticks(12, 8'hA0, "b_hold");
        step(8'hE8, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, "b_off2");
        ticks(9, 8'hA0, "b_tick2_");
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, "b_expired");

        // reset mid-countdown drops motor_active without a clock edge
        step(8'hE9, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, "c_on");
        step(8'hE8, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, "c_off");
        ticks(3, 8'hA0, "c_tick");
        reset = 1'b1;
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, "c_rst_async");
        reset = 1'b0;
        step(8'hED, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, "c_after");

        @(negedge clk);
        if (sb_e.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_e.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
